// File: rtl/mxv_scheduler_pkg.sv
// mxv_scheduler_pkg
// Shared definitions for the matrix-vector scheduler: FSM state type,
// dimension constants, the grouped control-strobe struct and a helper that
// turns an active-row count into a per-PE enable mask.
package mxv_scheduler_pkg;

  localparam int MXV_MAX_N    = 8;
  localparam int MXV_PE_COUNT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    PUSH  = 3'd4,
    DONE  = 3'd5
  } MXV_SCHED_STATE;

  // Every strobe the scheduler drives toward the FIFOs and PEs.
  typedef struct packed {
    logic       pop_vector;
    logic       vec_recirculate;
    logic [3:0] pop_row;
    logic       pe_clear;
    logic       pe_accumulate;
    logic       push_out;
  } MXV_SCHED_CONTROL;

  // Rows 0..rows-1 enabled; anything outside 1..4 enables nothing.
  function automatic logic [3:0] row_mask(input logic [3:0] rows);
    logic [3:0] mask;
    case (rows)
      4'd1:    mask = 4'b0001;
      4'd2:    mask = 4'b0011;
      4'd3:    mask = 4'b0111;
      4'd4:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mxv_scheduler_counter.sv
// CounterParameter
// Wrapping up-counter, 0..Maximum_Value-1, used as the MAC beat index k.
// Ports: clk, reset (async active-low), clear (sync zero), enable (count up),
// count (current value).
module CounterParameter #(
  parameter int Maximum_Value = 16,
  parameter int WIDTH         = $clog2(Maximum_Value)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(Maximum_Value - 1);

  // Count register: clear wins over enable, wraps after LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mxv_scheduler.sv
// mxv_scheduler
// Sequences operand pops into four MAC PEs and result pushes into the output
// FIFO. N<=4 runs one pass; 5<=N<=8 runs two passes, recirculating the vector
// during pass 0 so it is available again for pass 1.
// Ports:
//   clk, reset (async active-low)
//   start, N               : request and matrix dimension (N latched on accept)
//   vec_empty, row_empty   : input FIFO empty flags
//   out_full               : output FIFO full
//   pop_vector, vec_recirculate, pop_row, pe_clear, pe_accumulate,
//   result_sel, push_out   : datapath strobes (decoded from state + handshakes)
//   busy, done, error      : status
module mxv_scheduler
  import mxv_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] N,
  input  logic       vec_empty,
  input  logic [3:0] row_empty,
  input  logic       out_full,
  output logic       pop_vector,
  output logic       vec_recirculate,
  output logic [3:0] pop_row,
  output logic       pe_clear,
  output logic       pe_accumulate,
  output logic [1:0] result_sel,
  output logic       push_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  MXV_SCHED_STATE   state_r;
  MXV_SCHED_CONTROL ctrl_s;
  logic [3:0]       n_r;
  logic             pass_r;
  logic [3:0]       r_r;
  logic             error_r;
  logic [3:0]       k_s;
  logic [3:0]       rows_s;
  logic [3:0]       mask_s;
  logic             two_pass_s;
  logic             mac_ready_s;
  logic             n_legal_s;

  localparam logic [3:0] PE_CNT = 4'(MXV_PE_COUNT);
  localparam logic [3:0] MAX_N  = 4'(MXV_MAX_N);

  assign two_pass_s  = (n_r > PE_CNT);
  // Pass 1 handles the rows left over after the first four.
  assign rows_s      = pass_r ? (n_r - PE_CNT) : (two_pass_s ? PE_CNT : n_r);
  assign mask_s      = row_mask(rows_s);
  // Only row FIFOs feeding active PEs may stall a beat.
  assign mac_ready_s = ~vec_empty & ~(|(row_empty & mask_s));
  assign n_legal_s   = (N != 4'd0) && (N <= MAX_N);

  CounterParameter #(.Maximum_Value(16)) u_k_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_r == CLEAR),
    .enable (ctrl_s.pe_accumulate),
    .count  (k_s)
  );

  // Strobe decode from current state and the handshake relevant to it.
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      CLEAR: begin
        ctrl_s.pe_clear = 1'b1;
      end
      MAC: begin
        if (mac_ready_s) begin
          ctrl_s.pop_vector      = 1'b1;
          ctrl_s.pop_row         = mask_s;
          ctrl_s.pe_accumulate   = 1'b1;
          ctrl_s.vec_recirculate = ~pass_r & two_pass_s;
        end else begin
          ctrl_s = '0;
        end
      end
      PUSH: begin
        if (!out_full) begin
          ctrl_s.push_out = 1'b1;
        end else begin
          ctrl_s.push_out = 1'b0;
        end
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

  // Sequencer: state, latched N, pass, result index and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      n_r     <= 4'd0;
      pass_r  <= 1'b0;
      r_r     <= 4'd0;
      error_r <= 1'b0;
    end else begin
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (n_legal_s) begin
              n_r     <= N;
              pass_r  <= 1'b0;
              state_r <= CLEAR;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        CLEAR: state_r <= MAC;
        MAC: begin
          if (mac_ready_s && (k_s == n_r - 4'd1)) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          r_r     <= 4'd0;
          state_r <= PUSH;
        end
        PUSH: begin
          if (!out_full) begin
            if (r_r == rows_s - 4'd1) begin
              if (!pass_r && two_pass_s) begin
                pass_r  <= 1'b1;
                state_r <= CLEAR;
              end else begin
                state_r <= DONE;
              end
            end else begin
              r_r <= r_r + 4'd1;
            end
          end
        end
        DONE: begin
          pass_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign pop_vector      = ctrl_s.pop_vector;
  assign vec_recirculate = ctrl_s.vec_recirculate;
  assign pop_row         = ctrl_s.pop_row;
  assign pe_clear        = ctrl_s.pe_clear;
  assign pe_accumulate   = ctrl_s.pe_accumulate;
  assign push_out        = ctrl_s.push_out;
  assign result_sel      = r_r[1:0];
  assign busy            = (state_r != IDLE);
  assign done            = (state_r == DONE);
  assign error           = error_r;

endmodule

// File: tb/tb_mxv_scheduler.sv
// tb_mxv_scheduler
// Scoreboard bench: each run pushes its expected event stream (clear, MAC
// beats, pushes, done/error with cycle stamps); a negedge monitor pops and
// compares whenever the DUT shows a strobe.
module tb_mxv_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] N;
  logic       vec_empty;
  logic [3:0] row_empty;
  logic       out_full;
  logic       pop_vector, vec_recirculate, pe_clear, pe_accumulate;
  logic [3:0] pop_row;
  logic [1:0] result_sel;
  logic       push_out, busy, done, error;

  mxv_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .N(N),
    .vec_empty(vec_empty), .row_empty(row_empty), .out_full(out_full),
    .pop_vector(pop_vector), .vec_recirculate(vec_recirculate),
    .pop_row(pop_row), .pe_clear(pe_clear), .pe_accumulate(pe_accumulate),
    .result_sel(result_sel), .push_out(push_out),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int EV_CLR = 0, EV_MAC = 1, EV_PUSH = 2, EV_DONE = 3, EV_ERR = 4;

  typedef struct { int kind; int val; } ev_t;
  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic expect_ev(input int kind, input int act_val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got unexpected event value %0d, expected no event", name, act_val);
    end else begin
      e = exp_q.pop_front();
      check(name, kind * 1000000 + act_val, e.kind * 1000000 + e.val);
    end
  endtask

  function automatic void push_ev(input int kind, input int val);
    exp_q.push_back('{kind, val});
  endfunction

  function automatic int mask_of(input int rows);
    case (rows)
      1:       return 1;
      2:       return 3;
      3:       return 7;
      4:       return 15;
      default: return 0;
    endcase
  endfunction

  // MAC beat word: {pop_row, vec_recirculate, pe_accumulate, pop_vector}
  function automatic int mac_word(input int rows, input int rec);
    return (mask_of(rows) << 3) | (rec << 2) | 3;
  endfunction

  // Monitor: every visible strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pe_clear) expect_ev(EV_CLR, 0, "clear");
    if (pop_vector | pe_accumulate | vec_recirculate | (|pop_row))
      expect_ev(EV_MAC, {pop_row, vec_recirculate, pe_accumulate, pop_vector}, "mac_beat");
    if (push_out) expect_ev(EV_PUSH, result_sel, "push_sel");
    if (done)     expect_ev(EV_DONE, cyc, "done_cycle");
    if (error)    expect_ev(EV_ERR, cyc, "error_cycle");
  end

  // Issue start with n; abort_beats>=0 expects only clear + that many beats.
  task automatic run(input int n, input int stall, input int abort_beats);
    int r0, r1, s, beats;
    r0 = (n > 4) ? 4 : n;
    r1 = (n > 4) ? n - 4 : 0;
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1;
    N = 4'(n);
    if (n == 0 || n > 8) begin
      push_ev(EV_ERR, s + 1);
    end else begin
      beats = (abort_beats >= 0) ? abort_beats : n;
      push_ev(EV_CLR, 0);
      for (int b = 0; b < beats; b++) push_ev(EV_MAC, mac_word(r0, (n > 4) ? 1 : 0));
      if (abort_beats < 0) begin
        for (int r = 0; r < r0; r++) push_ev(EV_PUSH, r);
        if (n > 4) begin
          push_ev(EV_CLR, 0);
          for (int b = 0; b < n; b++) push_ev(EV_MAC, mac_word(r1, 0));
          for (int r = 0; r < r1; r++) push_ev(EV_PUSH, r);
        end
        push_ev(EV_DONE, s + 3 + n + r0 + ((n > 4) ? (2 + n + r1) : 0) + stall);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; N = 4'd0;
    vec_empty = 1'b0; row_empty = 4'd0; out_full = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {pop_vector, vec_recirculate, pop_row, pe_clear, pe_accumulate,
                            result_sel, push_out, busy, done, error}, 0);
    @(posedge clk); #1 reset = 1'b1;

    // N=3, with a start during MAC and N changing while busy
    run(3, 0, -1);
    @(posedge clk); #1 start = 1'b1; N = 4'd3;
    @(posedge clk); #1 start = 1'b0; N = 4'd7;
    wait_drain("n3");

    // N=6 two-pass
    run(6, 0, -1);
    wait_drain("n6");

    // N=4, vec_empty for 2 MAC cycles (out_full toggled too, irrelevant in MAC)
    run(4, 2, -1);
    repeat (3) @(posedge clk);
    #1 vec_empty = 1'b1; out_full = 1'b1;
    repeat (2) @(posedge clk);
    #1 vec_empty = 1'b0; out_full = 1'b0;
    wait_drain("n4_stall");

    // N=2, out_full on first PUSH cycle; inactive rows empty must not block
    row_empty = 4'b1100;
    run(2, 1, -1);
    repeat (4) @(posedge clk);
    #1 out_full = 1'b1;
    @(negedge clk);
    check("push_stall_push_out", push_out, 0);
    check("push_stall_sel", result_sel, 0);
    @(posedge clk); #1 out_full = 1'b0;
    wait_drain("n2_full");
    row_empty = 4'b0000;

    // illegal N
    run(0, 0, -1);
    wait_drain("n0_err");
    run(9, 0, -1);
    wait_drain("n9_err");

    // reset during MAC with N=8 after two beats
    run(8, 0, 2);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", {pop_vector, vec_recirculate, pop_row, pe_clear, pe_accumulate,
                            result_sel, push_out, busy, done, error}, 0);
    check("abort_beats_left", exp_q.size(), 0);
    @(posedge clk); #1 reset = 1'b1;
    run(1, 0, -1);
    wait_drain("n1_after_reset");

    check("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
